vga_display_sched: RTL and testbench

VGA_DISPLAY_SCHED -- requirements
Module: vga_display_sched

---
 rtl/vga_pkg.sv | 28 ++
 rtl/vga_timing_gen.sv | 85 ++++++++
 rtl/vga_display_sched.sv | 133 +++++++++++++
 tb/tb_vga_display_sched.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA display scheduler.
// Holds the display FSM state type, the default 800x480 timing constants
// and the saturation limit of the underflow event counter.
package vga_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_FILL,
        ST_WAIT_FRAME,
        ST_DISPLAY,
        ST_RESYNC
    } vga_state_t;

    // Default horizontal timing, in pixels.
    localparam int unsigned VGA_HDISP  = 800;
    localparam int unsigned VGA_HFP    = 40;
    localparam int unsigned VGA_HPULSE = 48;
    localparam int unsigned VGA_HBP    = 40;

    // Default vertical timing, in lines.
    localparam int unsigned VGA_VDISP  = 480;
    localparam int unsigned VGA_VFP    = 13;
    localparam int unsigned VGA_VPULSE = 3;
    localparam int unsigned VGA_VBP    = 29;

    localparam logic [15:0] UF_CNT_MAX = '1;

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running VGA timing generator.
// Ports:
//   pixel_clk, pixel_rst : pixel clock, asynchronous active-high reset
//   active               : combinational, current counters lie in the active area
//   frame_last           : combinational, counters at the last pixel of the frame
//   hs, vs               : registered sync outputs, active-low
//   blank                : registered active condition (1 = active video)
// Line layout: front porch, sync pulse, back porch, then active pixels;
// the frame is laid out the same way in lines.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned HDISP  = VGA_HDISP,
    parameter int unsigned VDISP  = VGA_VDISP,
    parameter int unsigned HFP    = VGA_HFP,
    parameter int unsigned HPULSE = VGA_HPULSE,
    parameter int unsigned HBP    = VGA_HBP,
    parameter int unsigned VFP    = VGA_VFP,
    parameter int unsigned VPULSE = VGA_VPULSE,
    parameter int unsigned VBP    = VGA_VBP
) (
    input  logic pixel_clk,
    input  logic pixel_rst,
    output logic active,
    output logic frame_last,
    output logic hs,
    output logic vs,
    output logic blank
);

    localparam int unsigned H_TOTAL = HFP + HPULSE + HBP + HDISP;
    localparam int unsigned V_TOTAL = VFP + VPULSE + VBP + VDISP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(HFP + HPULSE + HBP);
    localparam logic [VW-1:0] V_ACT    = VW'(VFP + VPULSE + VBP);
    localparam logic [HW-1:0] HS_START = HW'(HFP);
    localparam logic [HW-1:0] HS_END   = HW'(HFP + HPULSE);
    localparam logic [VW-1:0] VS_START = VW'(VFP);
    localparam logic [VW-1:0] VS_END   = VW'(VFP + VPULSE);

    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
    logic          h_last;
    logic          v_last;
    logic          hs_pulse;
    logic          vs_pulse;

    assign h_last     = (hcount == H_LAST);
    assign v_last     = (vcount == V_LAST);
    assign frame_last = h_last && v_last;
    assign active     = (hcount >= H_ACT) && (vcount >= V_ACT);
    assign hs_pulse   = (hcount >= HS_START) && (hcount < HS_END);
    assign vs_pulse   = (vcount >= VS_START) && (vcount < VS_END);

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            hcount <= '0;
            vcount <= '0;
        end else begin
            if (h_last) begin
                hcount <= '0;
                vcount <= v_last ? '0 : vcount + 1'b1;
            end else begin
                hcount <= hcount + 1'b1;
            end
        end
    end

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            hs    <= 1'b1;
            vs    <= 1'b1;
            blank <= 1'b0;
        end else begin
            hs    <= ~hs_pulse;
            vs    <= ~vs_pulse;
            blank <= active;
        end
    end

endmodule

// File: rtl/vga_display_sched.sv
// VGA display scheduler: pops pixels from a show-ahead FIFO during the
// active area, waits for the FIFO to fill and for a frame boundary before
// displaying, and recovers from FIFO underflow by flushing and refilling.
// Ports:
//   pixel_clk, pixel_rst       : pixel clock, asynchronous active-high reset
//   enable                     : display enable request
//   fifo_rdata, fifo_rempty    : FIFO head and empty flag
//   fifo_wfull                 : FIFO full flag (already in pixel_clk domain)
//   fifo_rd                    : combinational pop strobe
//   fifo_flush                 : one-cycle FIFO flush / reader restart request
//   hs, vs, blank, rgb         : registered video outputs
//   displaying                 : high while in DISPLAY
//   underflow_cnt              : saturating underflow event count
module vga_display_sched
    import vga_pkg::*;
#(
    parameter int unsigned HDISP  = VGA_HDISP,
    parameter int unsigned VDISP  = VGA_VDISP,
    parameter int unsigned HFP    = VGA_HFP,
    parameter int unsigned HPULSE = VGA_HPULSE,
    parameter int unsigned HBP    = VGA_HBP,
    parameter int unsigned VFP    = VGA_VFP,
    parameter int unsigned VPULSE = VGA_VPULSE,
    parameter int unsigned VBP    = VGA_VBP
) (
    input  logic        pixel_clk,
    input  logic        pixel_rst,
    input  logic        enable,
    input  logic [23:0] fifo_rdata,
    input  logic        fifo_rempty,
    input  logic        fifo_wfull,
    output logic        fifo_rd,
    output logic        fifo_flush,
    output logic        hs,
    output logic        vs,
    output logic        blank,
    output logic [23:0] rgb,
    output logic        displaying,
    output logic [15:0] underflow_cnt
);

    vga_state_t state;
    logic       active;
    logic       frame_last;
    logic       underflow;

    vga_timing_gen #(
        .HDISP  (HDISP),
        .VDISP  (VDISP),
        .HFP    (HFP),
        .HPULSE (HPULSE),
        .HBP    (HBP),
        .VFP    (VFP),
        .VPULSE (VPULSE),
        .VBP    (VBP)
    ) u_timing (
        .pixel_clk  (pixel_clk),
        .pixel_rst  (pixel_rst),
        .active     (active),
        .frame_last (frame_last),
        .hs         (hs),
        .vs         (vs),
        .blank      (blank)
    );

    assign fifo_rd   = active && (state == ST_DISPLAY);
    assign underflow = fifo_rd && fifo_rempty;

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            rgb <= '0;
        end else begin
            rgb <= fifo_rd ? fifo_rdata : '0;
        end
    end

    // The end-of-frame exit is "pending" for as long as enable stays low;
    // sampling enable only at the last pixel lets a re-assertion cancel it.
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            state         <= ST_IDLE;
            displaying    <= 1'b0;
            fifo_flush    <= 1'b0;
            underflow_cnt <= '0;
        end else begin
            fifo_flush <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state <= ST_WAIT_FILL;
                    end
                end
                ST_WAIT_FILL: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                    end else if (fifo_wfull) begin
                        state <= ST_WAIT_FRAME;
                    end
                end
                ST_WAIT_FRAME: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                    end else if (frame_last) begin
                        state      <= ST_DISPLAY;
                        displaying <= 1'b1;
                    end
                end
                ST_DISPLAY: begin
                    if (underflow) begin
                        state      <= ST_RESYNC;
                        displaying <= 1'b0;
                        fifo_flush <= 1'b1;
                        if (underflow_cnt != UF_CNT_MAX) begin
                            underflow_cnt <= underflow_cnt + 16'd1;
                        end
                    end else if (!enable && frame_last) begin
                        state      <= ST_IDLE;
                        displaying <= 1'b0;
                        fifo_flush <= 1'b1;
                    end
                end
                ST_RESYNC: begin
                    state <= ST_WAIT_FILL;
                end
                default: begin
                    state      <= ST_IDLE;
                    displaying <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_display_sched.sv
// Self-checking bench for vga_display_sched using a reduced 15x8 timing
// so that whole frames fit in a short run.
module tb_vga_display_sched;

    localparam int HDISP = 8, VDISP = 4;
    localparam int HFP = 2, HPULSE = 3, HBP = 2;
    localparam int VFP = 1, VPULSE = 2, VBP = 1;
    localparam int HT = HFP + HPULSE + HBP + HDISP;   // 15
    localparam int VT = VFP + VPULSE + VBP + VDISP;   // 8
    localparam int HA = HFP + HPULSE + HBP;           // 7
    localparam int VA = VFP + VPULSE + VBP;           // 4

    localparam int M_IDLE = 0, M_FILL = 1, M_FRAME = 2, M_DISP = 3, M_RESYNC = 4;

    logic        pixel_clk = 1'b0;
    logic        pixel_rst = 1'b1;
    logic        enable = 1'b0;
    logic [23:0] fifo_rdata;
    logic        fifo_rempty = 1'b0;
    logic        fifo_wfull = 1'b0;
    logic        fifo_rd;
    logic        fifo_flush;
    logic        hs, vs, blank;
    logic [23:0] rgb;
    logic        displaying;
    logic [15:0] underflow_cnt;

    int tests = 0;
    int fails = 0;

    vga_display_sched #(
        .HDISP(HDISP), .VDISP(VDISP),
        .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
        .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP)
    ) dut (
        .pixel_clk     (pixel_clk),
        .pixel_rst     (pixel_rst),
        .enable        (enable),
        .fifo_rdata    (fifo_rdata),
        .fifo_rempty   (fifo_rempty),
        .fifo_wfull    (fifo_wfull),
        .fifo_rd       (fifo_rd),
        .fifo_flush    (fifo_flush),
        .hs            (hs),
        .vs            (vs),
        .blank         (blank),
        .rgb           (rgb),
        .displaying    (displaying),
        .underflow_cnt (underflow_cnt)
    );

    always #5 pixel_clk = ~pixel_clk;

    // Show-ahead FIFO emulation: a ramp that advances on every real pop.
    logic [23:0] ramp = 24'h010203;
    assign fifo_rdata = ramp;
    always @(posedge pixel_clk) begin
        if (fifo_rd && !fifo_rempty) ramp <= ramp + 24'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          mh = 0, mv = 0;         // counters of the current cycle
    int          mst = M_IDLE;
    int          mcnt = 0;
    logic [23:0] mdata = 24'h010203;     // FIFO head as the model sees it
    logic        e_hs = 1, e_vs = 1, e_blank = 0, e_flush = 0, e_rd = 0, e_disp = 0;
    logic [23:0] e_rgb = '0;

    function automatic logic in_active(int h, int v);
        return (h >= HA) && (v >= VA);
    endfunction

    task automatic model_step();
        logic act, rd, uf, eof;
        act = in_active(mh, mv);
        rd  = act && (mst == M_DISP);
        uf  = rd && fifo_rempty;
        eof = (mh == HT - 1) && (mv == VT - 1);
        e_hs    = !((mh >= HFP) && (mh < HFP + HPULSE));
        e_vs    = !((mv >= VFP) && (mv < VFP + VPULSE));
        e_blank = act;
        e_rgb   = rd ? mdata : 24'h0;
        if (rd && !fifo_rempty) mdata = mdata + 24'd1;
        e_flush = 1'b0;
        case (mst)
            M_IDLE:   if (enable) mst = M_FILL;
            M_FILL:   if (!enable) mst = M_IDLE; else if (fifo_wfull) mst = M_FRAME;
            M_FRAME:  if (!enable) mst = M_IDLE; else if (eof) mst = M_DISP;
            M_DISP: begin
                if (uf) begin
                    mst = M_RESYNC; e_flush = 1'b1;
                    if (mcnt < 65535) mcnt++;
                end else if (!enable && eof) begin
                    mst = M_IDLE; e_flush = 1'b1;
                end
            end
            default:  mst = M_FILL;
        endcase
        mh = (mh + 1) % HT;
        if (mh == 0) mv = (mv + 1) % VT;
        e_disp = (mst == M_DISP);
        e_rd   = in_active(mh, mv) && (mst == M_DISP);
    endtask

    task automatic model_reset();
        mh = 0; mv = 0; mst = M_IDLE; mcnt = 0;
        e_hs = 1; e_vs = 1; e_blank = 0; e_rgb = '0;
        e_flush = 0; e_rd = 0; e_disp = 0;
    endtask

    // Compare process: outputs are stable at the falling edge.
    always @(negedge pixel_clk) begin
        if (pixel_rst) model_reset();
        else model_step();
        check("hs", hs, e_hs);
        check("vs", vs, e_vs);
        check("blank", blank, e_blank);
        check("rgb", rgb, e_rgb);
        check("fifo_rd", fifo_rd, e_rd);
        check("fifo_flush", fifo_flush, e_flush);
        check("displaying", displaying, e_disp);
        check("underflow_cnt", underflow_cnt, mcnt);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge pixel_clk);
        #1;
    endtask

    task automatic wait_hv(input int h, input int v);
        int n = 0;
        while (!(mh == h && mv == v) && n < 2000) begin tick(); n++; end
        if (n >= 2000) check("wait_hv_timeout", 1, 0);
    endtask

    task automatic wait_disp(input logic val);
        int n = 0;
        while (displaying !== val && n < 2000) begin tick(); n++; end
        if (n >= 2000) check("wait_disp_timeout", 1, 0);
    endtask

    initial begin
        int hs_low, vs_low, blk, pops, first_h, first_v, flushes;

        repeat (3) tick();
        check("rst_hs", hs, 1);
        check("rst_vs", vs, 1);
        check("rst_blank", blank, 0);
        check("rst_rgb", rgb, 0);
        check("rst_fifo_rd", fifo_rd, 0);
        check("rst_flush", fifo_flush, 0);
        check("rst_displaying", displaying, 0);
        check("rst_ucnt", underflow_cnt, 0);
        pixel_rst = 1'b0;

        // Free run, display disabled: sync/blank duty over one frame.
        tick();
        wait_hv(0, 0);
        hs_low = 0; vs_low = 0; blk = 0;
        for (int i = 0; i < HT * VT; i++) begin
            tick();
            if (!hs) hs_low++;
            if (!vs) vs_low++;
            if (blank) blk++;
        end
        check("hs_low_per_frame", hs_low, 24);
        check("vs_low_per_frame", vs_low, 30);
        check("blank_per_frame", blk, 32);

        // Enable with a full FIFO: start at frame boundary, 32 pops per frame.
        enable = 1'b1; fifo_wfull = 1'b1;
        wait_disp(1'b1);
        check("disp_start_h", mh, 0);
        check("disp_start_v", mv, 0);
        pops = 0; first_h = -1; first_v = -1;
        for (int i = 0; i < HT * VT; i++) begin
            if (fifo_rd) begin
                if (pops == 0) begin first_h = mh; first_v = mv; end
                pops++;
            end
            tick();
        end
        check("first_rd_h", first_h, 7);
        check("first_rd_v", first_v, 4);
        check("pops_per_frame", pops, 32);

        // Underflow at pixel 3 of active line 2.
        wait_hv(HA + 3, VA + 2);
        fifo_wfull = 1'b0; fifo_rempty = 1'b1;
        tick();
        fifo_rempty = 1'b0;
        check("uf_cnt", underflow_cnt, 1);
        check("uf_flush", fifo_flush, 1);
        check("uf_displaying", displaying, 0);
        flushes = 0; pops = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (fifo_flush) flushes++;
            if (fifo_rd) pops++;
        end
        check("uf_extra_flush", flushes, 0);
        check("uf_no_pops", pops, 0);
        fifo_wfull = 1'b1;
        wait_disp(1'b1);
        check("resume_h", mh, 0);
        check("resume_v", mv, 0);

        // Drop enable mid-frame: finish the frame then flush once.
        wait_hv(HA + 1, VA + 1);
        enable = 1'b0;
        wait_disp(1'b0);
        check("exit_h", mh, 0);
        check("exit_v", mv, 0);
        check("exit_flush", fifo_flush, 1);
        tick();
        check("exit_flush_once", fifo_flush, 0);

        // Re-enable before frame end cancels the exit.
        enable = 1'b1;
        wait_disp(1'b1);
        wait_hv(HA, VA + 1);
        enable = 1'b0;
        repeat (5) tick();
        enable = 1'b1;
        flushes = 0;
        while (!(mh == 0 && mv == 0)) begin
            if (fifo_flush) flushes++;
            tick();
        end
        check("cancel_displaying", displaying, 1);
        check("cancel_no_flush", flushes, 0);

        // Underflow on last active pixel with enable low: RESYNC wins.
        wait_hv(HT - 1, VT - 1);
        enable = 1'b0; fifo_rempty = 1'b1;
        tick();
        fifo_rempty = 1'b0;
        check("last_uf_cnt", underflow_cnt, 2);
        check("last_uf_flush", fifo_flush, 1);
        repeat (3) tick();
        check("last_uf_idle", displaying, 0);

        // Asynchronous reset mid-frame.
        enable = 1'b1;
        wait_disp(1'b1);
        wait_hv(HA + 2, VA + 1);
        pixel_rst = 1'b1;
        #1;
        check("arst_hs", hs, 1);
        check("arst_blank", blank, 0);
        check("arst_rd", fifo_rd, 0);
        check("arst_flush", fifo_flush, 0);
        check("arst_disp", displaying, 0);
        check("arst_ucnt", underflow_cnt, 0);
        repeat (3) tick();
        pixel_rst = 1'b0;
        repeat (30) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
